half_stream_activate: RTL and testbench
=======================================

# half_stream_activate

Per-neuron bias-add and activation stage placed directly downstream of the half-precision stream accumulator. Each valid accumulated dot-product (one per neuron) gets that neuron's bias from a small local bias memory added to it, then goes through ReLU (or leaky ReLU) and leaves tagged with its neuron index. This turns a stream of raw sums into a layer's activation vector for the next layer.

## Interface
Parameters:
- BITS, 16, data width (IEEE 754 binary16; only 16 supported)
- NEURONS, 10, neurons per layer; bias memory depth and index wrap point
- LEAK_SHIFT, 3, leaky-ReLU slope 2^-LEAK_SHIFT (used only with LEAKY_RELU_EN)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  a holds an accumulated sum this cycle
- a  in  BITS  accumulated sum, binary16
- bias_we  in  1  bias memory write strobe
- bias_addr  in  $clog2(NEURONS)  bias write address
- bias_data  in  BITS  bias value, binary16
- out_valid  out  1  c/out_index valid this cycle
- c  out  BITS  activated result; 0 when out_valid low
- out_index  out  $clog2(NEURONS)  neuron index of c; 0 when out_valid low
- out_last  out  1  high with out_valid when out_index == NEURONS-1

## Operation
- Neuron counter idx: increments on every in_valid cycle, wraps NEURONS-1 -> 0. Not cleared by in_valid gaps; only rstn clears it.
- Bias memory: NEURONS x BITS, zero at time zero, not cleared by rstn. Write on bias_we at clock edge. Read of idx in the same cycle as a write to the same address returns the old value.
- Addition: the codebase half_add (1-cycle registered), a + bias[idx].
- Activation on the sum s:
  - s sign 0 (incl. +inf): pass unchanged.
  - s NaN (exp 31, mant != 0): pass unchanged.
  - s sign 1 (incl. -0, -inf), no macro: output 16'h0000.
- No backpressure; a fully pipelined stream of one sum per cycle is accepted.

## Timing
- Three stages: S0 registers a, idx, bias[idx]; S1 half_add; S2 activation register.
- in_valid at edge N -> out_valid, c, out_index, out_last at edge N+3.
- Back-to-back inputs give back-to-back outputs in order.
- Reset values: out_valid 0, c 0, out_index 0, out_last 0, idx 0, all stage valids 0.
- rstn low mid-stream: all outputs drop to 0 immediately and in-flight data is discarded. The first input after release is index 0. Bias contents are kept.
- bias_we may be used at any time. A write lands before the S0 read one cycle later.

## Configuration
- LEAKY_RELU_EN defined: negative finite s is scaled by subtracting LEAK_SHIFT from the exponent, keeping sign and mantissa.
  - If exp <= LEAK_SHIFT (result subnormal or underflow), output 16'h8000.
  - -inf passes unchanged.
  - -0 outputs 16'h8000.
- LEAKY_RELU_EN undefined: plain ReLU as in Operation. LEAK_SHIFT is ignored.

## Structure
- Shared package (half_pkg): binary16 field widths/offsets, constants HALF_POS_ZERO, HALF_NEG_ZERO, HALF_EXP_MAX, and an is_nan helper.
- Sub-module: reuse the existing half_add. The activation function is a local function, not a separate module.

## Test plan
- bias[0]=16'h4000 (2.0); a=16'h3C00 (1.0) at cycle N -> c=16'h4200 (3.0), out_index=0, out_valid at N+3.
- bias[1]=16'h3C00; a=16'hC400 (-4.0), s=-3.0:
  - macro off -> c=16'h0000.
  - LEAKY_RELU_EN, LEAK_SHIFT=3 -> c=16'hB600 (-0.375).
- NEURONS=10, 11 consecutive in_valid cycles -> out_index 0..9 then 0; out_last only on index 9; one output per cycle.
- a=16'h7E00 (NaN), bias 0 -> c=16'h7E00. a=16'hFC00 (-inf) -> c=16'h0000 (macro off).
- rstn pulsed low while 2 results are in flight -> outputs 0 at once, no stale out_valid after release; next input reports out_index 0; biases unchanged.
- Write bias[2]=16'h3800 in the same cycle idx=2 is read -> that result uses the old bias; the next pass through index 2 uses 0.5.

Source files
------------

// File: rtl/half_pkg.sv
// Shared binary16 definitions: field layout, special encodings and classification helpers.
package half_pkg;

  localparam int HALF_W        = 16;
  localparam int HALF_EXP_W    = 5;
  localparam int HALF_MANT_W   = 10;
  localparam int HALF_EXP_LSB  = 10;
  localparam int HALF_SIGN_BIT = 15;

  localparam logic [HALF_EXP_W-1:0] HALF_EXP_MAX  = 5'd31;
  localparam logic [HALF_W-1:0]     HALF_POS_ZERO = 16'h0000;
  localparam logic [HALF_W-1:0]     HALF_NEG_ZERO = 16'h8000;
  localparam logic [HALF_W-1:0]     HALF_QNAN     = 16'h7E00;
  localparam logic [HALF_W-1:0]     HALF_POS_INF  = 16'h7C00;

  typedef struct packed {
    logic                   sign;
    logic [HALF_EXP_W-1:0]  exp;
    logic [HALF_MANT_W-1:0] mant;
  } half_t;

  function automatic logic is_nan(input logic [HALF_W-1:0] h);
    return (h[HALF_EXP_LSB +: HALF_EXP_W] == HALF_EXP_MAX) && (h[HALF_MANT_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [HALF_W-1:0] h);
    return (h[HALF_EXP_LSB +: HALF_EXP_W] == HALF_EXP_MAX) && (h[HALF_MANT_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/half_stream_activate_if.sv
// Stream, bias-write and result signals of half_stream_activate, with master/slave views.
interface half_stream_activate_if #(
  parameter int BITS    = 16,
  parameter int NEURONS = 10
);
  localparam int IW = $clog2(NEURONS);

  logic            in_valid;
  logic [BITS-1:0] a;
  logic            bias_we;
  logic [IW-1:0]   bias_addr;
  logic [BITS-1:0] bias_data;
  logic            out_valid;
  logic [BITS-1:0] c;
  logic [IW-1:0]   out_index;
  logic            out_last;

  modport master (
    output in_valid, a, bias_we, bias_addr, bias_data,
    input  out_valid, c, out_index, out_last
  );

  modport slave (
    input  in_valid, a, bias_we, bias_addr, bias_data,
    output out_valid, c, out_index, out_last
  );
endinterface

// File: rtl/half_add.sv
// binary16 adder, round-to-nearest-even, full subnormal support, one registered output stage.
module half_add
  import half_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c
);

  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd14;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(13 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  half_t       x, y;
  logic [5:0]  ex, ey, d, e_norm;
  logic [3:0]  dc, lz, sh;
  logic [13:0] mx, my, ay, norm;
  logic [28:0] ext;
  logic [14:0] sum, mag;
  logic [4:0]  e_field;
  logic        rnd, sign;
  logic [15:0] c_next;

  always_comb begin
    // x always carries the larger magnitude so the aligned difference is never negative
    x      = (a[14:0] >= b[14:0]) ? a : b;
    y      = (a[14:0] >= b[14:0]) ? b : a;
    ex     = (x.exp == '0) ? 6'd1 : {1'b0, x.exp};
    ey     = (y.exp == '0) ? 6'd1 : {1'b0, y.exp};
    d      = ex - ey;
    dc     = (d > 6'd15) ? 4'd15 : d[3:0];
    mx     = {x.exp != '0, x.mant, 3'b000};
    my     = {y.exp != '0, y.mant, 3'b000};
    ext    = {my, 15'b0} >> dc;
    ay     = {ext[28:16], ext[15] | (|ext[14:0])};
    sum    = (x.sign ^ y.sign) ? ({1'b0, mx} - {1'b0, ay}) : ({1'b0, mx} + {1'b0, ay});
    lz     = lzc14(sum[13:0]);
    sh     = 4'd0;
    norm   = '0;
    e_norm = ex;
    if (sum[14]) begin
      norm   = {sum[14:2], sum[1] | sum[0]};
      e_norm = ex + 6'd1;
    end else begin
      // normalisation stops at the subnormal boundary
      sh     = ({2'b00, lz} > (ex - 6'd1)) ? 4'(ex - 6'd1) : lz;
      norm   = sum[13:0] << sh;
      e_norm = ex - {2'b00, sh};
    end
    rnd     = norm[2] & (norm[1] | norm[0] | norm[3]);
    e_field = norm[13] ? e_norm[4:0] : 5'd0;
    mag     = {e_field, norm[12:3]} + {14'd0, rnd};
    if (norm[13] && e_norm >= 6'd31) mag = HALF_POS_INF[14:0];
    sign    = (sum == '0) ? (x.sign & y.sign) : x.sign;
    c_next  = {sign, mag};
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[15] != b[15])))
      c_next = HALF_QNAN;
    else if (is_inf(a))
      c_next = a;
    else if (is_inf(b))
      c_next = b;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) c <= HALF_POS_ZERO;
    else       c <= c_next;
  end

endmodule

// File: rtl/half_stream_activate.sv
// Per-neuron bias add plus ReLU over a binary16 stream; three stages, no backpressure.
// Define LEAKY_RELU_EN to scale negative sums by 2^-LEAK_SHIFT instead of zeroing them.
module half_stream_activate
  import half_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int NEURONS    = 10,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  half_stream_activate_if.slave   bus
);

  localparam int IW = $clog2(NEURONS);

  logic [BITS-1:0] bias_mem [NEURONS] = '{default: '0};
  logic [BITS-1:0] bias_q;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            s0_valid_reg, s1_valid_reg;
  logic [BITS-1:0] s0_a_reg;
  logic [IW-1:0]   s0_idx_reg, s1_idx_reg;
  logic [15:0]     s1_sum;
  logic            out_valid_reg, out_last_reg;
  logic [BITS-1:0] c_reg;
  logic [IW-1:0]   out_index_reg;

  function automatic logic [15:0] activate(input logic [15:0] s);
    half_t h;
    logic [15:0] r;
    h = s;
    r = s;
    if (h.sign && !is_nan(s)) begin
`ifdef LEAKY_RELU_EN
      if (h.exp == HALF_EXP_MAX)
        r = s;
      else if (int'(h.exp) <= LEAK_SHIFT)
        r = HALF_NEG_ZERO;
      else
        r = {1'b1, h.exp - 5'(LEAK_SHIFT), h.mant};
`else
      r = HALF_POS_ZERO;
`endif
    end
    return r;
  endfunction

  assign idx_next = (idx_reg == IW'(NEURONS - 1)) ? '0 : idx_reg + 1'b1;

  // bias storage survives reset; a same-edge write and read sees the old word
  always_ff @(posedge clk) begin
    if (bus.bias_we && (int'(bus.bias_addr) < NEURONS))
      bias_mem[bus.bias_addr] <= bus.bias_data;
    bias_q <= bias_mem[idx_reg];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_reg      <= '0;
      s0_valid_reg <= 1'b0;
      s0_a_reg     <= '0;
      s0_idx_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_idx_reg   <= '0;
    end else begin
      if (bus.in_valid) idx_reg <= idx_next;
      s0_valid_reg <= bus.in_valid;
      s0_a_reg     <= bus.a;
      s0_idx_reg   <= idx_reg;
      s1_valid_reg <= s0_valid_reg;
      s1_idx_reg   <= s0_idx_reg;
    end
  end

  half_add u_add (
    .clk  (clk),
    .rstn (rstn),
    .a    (s0_a_reg),
    .b    (bias_q),
    .c    (s1_sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_reg <= 1'b0;
      c_reg         <= '0;
      out_index_reg <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      c_reg         <= s1_valid_reg ? activate(s1_sum) : HALF_POS_ZERO;
      out_index_reg <= s1_valid_reg ? s1_idx_reg : '0;
      out_last_reg  <= s1_valid_reg && (s1_idx_reg == IW'(NEURONS - 1));
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.c         = c_reg;
  assign bus.out_index = out_index_reg;
  assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_half_stream_activate.sv
// Directed plus random stimulus for half_stream_activate against a real-arithmetic reference model.
module tb_half_stream_activate;

  localparam int NEURONS    = 10;
  localparam int LEAK_SHIFT = 3;

  typedef struct {
    int          due;
    logic [15:0] c;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   idx_m    = 0;
  logic [15:0] bias_m [NEURONS];
  exp_t q[$];

  half_stream_activate_if #(.BITS(16), .NEURONS(NEURONS)) bus ();

  half_stream_activate #(.BITS(16), .NEURONS(NEURONS), .LEAK_SHIFT(LEAK_SHIFT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic real p2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(int'(h[9:0])) * p2(-24);
    else        m = real'(1024 + int'(h[9:0])) * p2(e - 25);
    return h[15] ? -m : m;
  endfunction

  function automatic longint rne(input real x);
    longint f;
    real    fr;
    f  = longint'($floor(x));
    fr = x - real'(f);
    if (fr > 0.5 || (fr == 0.5 && f[0])) f++;
    return f;
  endfunction

  function automatic logic [15:0] r2h(input real v, input logic zsign);
    logic   s;
    real    mag;
    int     e;
    longint qi;
    if (v == 0.0) return {zsign, 15'h0};
    s   = (v < 0.0);
    mag = s ? -v : v;
    if (mag >= 65520.0) return {s, 15'h7C00};
    if (mag < p2(-14)) begin
      qi = rne(mag * p2(24));
      return {s, 15'(qi)};
    end
    e = 15;
    while (p2(e) > mag) e--;
    qi = rne(mag * p2(10 - e));
    return {s, 15'(longint'((e + 14) * 1024) + qi)};
  endfunction

  function automatic logic nan_m(input logic [15:0] h);
    return (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
  endfunction

  function automatic logic inf_m(input logic [15:0] h);
    return (h[14:10] == 5'd31) && (h[9:0] == 10'd0);
  endfunction

  function automatic logic [15:0] add_m(input logic [15:0] x, input logic [15:0] y);
    if (nan_m(x) || nan_m(y)) return 16'h7E00;
    if (inf_m(x) && inf_m(y)) return (x[15] == y[15]) ? x : 16'h7E00;
    if (inf_m(x)) return x;
    if (inf_m(y)) return y;
    return r2h(h2r(x) + h2r(y), x[15] & y[15]);
  endfunction

  function automatic logic [15:0] act_m(input logic [15:0] s);
    if (nan_m(s) || !s[15]) return s;
`ifdef LEAKY_RELU_EN
    if (inf_m(s)) return s;
    if (int'(s[14:10]) <= LEAK_SHIFT) return 16'h8000;
    return s - 16'(LEAK_SHIFT * 1024);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] v;
    if ($urandom_range(0, 1) == 1) v = 16'($urandom);
    else v = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_valid", {15'd0, bus.out_valid}, 16'd1);
      chk("c", bus.c, e.c);
      chk("out_index", {12'd0, bus.out_index}, {12'd0, e.idx});
      chk("out_last", {15'd0, bus.out_last}, {15'd0, e.last});
      $display("cycle %0d: out idx=%0d c=%h last=%0b (exp c=%h)", cyc, bus.out_index, bus.c, bus.out_last, e.c);
    end else begin
      chk("idle_valid", {15'd0, bus.out_valid}, 16'd0);
      chk("idle_c", bus.c, 16'd0);
      chk("idle_index", {12'd0, bus.out_index}, 16'd0);
      chk("idle_last", {15'd0, bus.out_last}, 16'd0);
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] av, input logic we, input logic [3:0] wa,
                      input logic [15:0] wd, input logic use_lit, input logic [15:0] lit);
    exp_t e;
    bus.in_valid  = iv;
    bus.a         = av;
    bus.bias_we   = we;
    bus.bias_addr = wa;
    bus.bias_data = wd;
    if (iv) begin
      e.c    = use_lit ? lit : act_m(add_m(av, bias_m[idx_m]));
      e.idx  = 4'(idx_m);
      e.last = (idx_m == NEURONS - 1);
      e.due  = cyc + 3;
      q.push_back(e);
      idx_m  = (idx_m == NEURONS - 1) ? 0 : idx_m + 1;
    end
    if (we) bias_m[wa] = wd;
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic feed(input logic [15:0] av);
    step(1'b1, av, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic feed_lit(input logic [15:0] av, input logic [15:0] lit);
    step(1'b1, av, 1'b0, 4'd0, 16'h0, 1'b1, lit);
  endtask

  task automatic write_bias(input logic [3:0] wa, input logic [15:0] wd);
    step(1'b0, 16'h0, 1'b1, wa, wd, 1'b0, 16'h0);
  endtask

  task automatic pulse_reset();
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.bias_we  = 1'b0;
    #1;
    chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_c", bus.c, 16'd0);
    chk("rst_index", {12'd0, bus.out_index}, 16'd0);
    chk("rst_last", {15'd0, bus.out_last}, 16'd0);
    q.delete();
    idx_m = 0;
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
    rstn = 1'b1;
  endtask

  logic [15:0] neg_lit, ninf_lit;

  initial begin
`ifdef LEAKY_RELU_EN
    neg_lit  = 16'hB600;
    ninf_lit = 16'hFC00;
`else
    neg_lit  = 16'h0000;
    ninf_lit = 16'h0000;
`endif
    for (int i = 0; i < NEURONS; i++) bias_m[i] = 16'h0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0;
    bus.bias_we   = 1'b0;
    bus.bias_addr = 4'd0;
    bus.bias_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rstn = 1'b1;

    write_bias(4'd0, 16'h4000);
    write_bias(4'd1, 16'h3C00);
    feed_lit(16'h3C00, 16'h4200);
    feed_lit(16'hC400, neg_lit);
    feed_lit(16'h7E00, 16'h7E00);
    feed_lit(16'hFC00, ninf_lit);
    idle(4);

    feed(16'h3C00);
    feed(16'h4000);
    pulse_reset();
    idle(5);

    feed_lit(16'h3C00, 16'h4200);
    feed_lit(16'hC400, neg_lit);
    for (int i = 0; i < 9; i++) feed(pick());

    feed(pick());
    step(1'b1, 16'h3C00, 1'b1, 4'd2, 16'h3800, 1'b1, 16'h3C00);
    for (int i = 0; i < 9; i++) feed(pick());
    feed_lit(16'h3C00, 16'h3E00);
    idle(4);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), pick(), ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, NEURONS - 1)), pick(), 1'b0, 16'h0);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
